// File: rtl/tile_sched.sv
// tile_sched: issues the GRID x GRID overlapping detection tiles of one frame, counts
// completions, then enables the merge stage. Define TILE_WDOG_EN to add the watchdog/ERR state.
module tile_sched #(
  parameter int unsigned GRID        = 6,
`ifdef TILE_WDOG_EN
  parameter int unsigned WDOG_CYCLES = 1000000,
`endif
  parameter int unsigned MAX_OUT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] size,
  input  logic        frame_start,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [5:0]  tile_id,
  output logic [31:0] tile_x,
  output logic [31:0] tile_y,
  output logic [31:0] tile_base,
  output logic [31:0] tile_len,
  input  logic        done_valid,
  output logic        merge_en,
  input  logic        merge_done,
  output logic        busy,
  output logic        frame_done,
`ifdef TILE_WDOG_EN
  output logic        wdog_err,
`endif
  output logic        cfg_err,
  output logic        proto_err
);

  localparam int unsigned   NTILES  = GRID * GRID;
  localparam int            CW      = $clog2(NTILES + 1);
  localparam int            OW      = 7;
  localparam logic [CW-1:0] N_LAST  = CW'(NTILES);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
  localparam logic [5:0]    GX_LAST = 6'(GRID - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_DISPATCH, S_WAIT, S_MERGE,
`ifdef TILE_WDOG_EN
    S_ERR,
`endif
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   size_q, unit_q, row_step, row_base;
  logic [5:0]    gx;
  logic [CW-1:0] issued, completed, issued_nxt, completed_nxt;
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic          accept, counting, done_ok, valid_nxt;

  // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
  always_comb begin
    accept          = tile_valid && tile_ready;
    counting        = (state == S_DISPATCH) || (state == S_WAIT);
    done_ok         = counting && done_valid && (outstanding != '0);
    issued_nxt      = issued + CW'(accept);
    completed_nxt   = completed + CW'(done_ok);
    outstanding_nxt = outstanding + OW'(accept) - OW'(done_ok);
    valid_nxt       = (issued_nxt < N_LAST) && (outstanding_nxt < OUT_MAX);
  end

`ifdef TILE_WDOG_EN
  logic [31:0] wdog_cnt, wdog_nxt;
  logic        wdog_active, wdog_trip;

  always_comb begin
    wdog_active = (state == S_DISPATCH) || (state == S_WAIT) || (state == S_MERGE);
    wdog_nxt    = (done_valid || merge_done) ? '0 : wdog_cnt + 32'd1;
    wdog_trip   = wdog_active && (wdog_nxt == WDOG_CYCLES);
  end
`endif

  // NOTE: state is updated with <= only, so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      size_q      <= '0;
      unit_q      <= '0;
      row_step    <= '0;
      row_base    <= '0;
      gx          <= '0;
      issued      <= '0;
      completed   <= '0;
      outstanding <= '0;
      tile_valid  <= 1'b0;
      tile_id     <= '0;
      tile_x      <= '0;
      tile_y      <= '0;
      tile_base   <= '0;
      tile_len    <= '0;
      merge_en    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      cfg_err     <= 1'b0;
      proto_err   <= 1'b0;
`ifdef TILE_WDOG_EN
      wdog_cnt    <= '0;
      wdog_err    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (done_valid && !done_ok) proto_err <= 1'b1;

      case (state)
        S_IDLE: if (frame_start) begin
          size_q    <= size;
          unit_q    <= size >> 3;
          cfg_err   <= 1'b0;
          proto_err <= done_valid;
          busy      <= 1'b1;
          state     <= S_CALC;
        end
        S_CALC: if (unit_q == '0) begin
          cfg_err    <= 1'b1;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end else begin
          // Row stride is precomputed so the dispatch loop needs only adders.
          row_step    <= unit_q * size_q;
          row_base    <= '0;
          gx          <= '0;
          issued      <= '0;
          completed   <= '0;
          outstanding <= '0;
          tile_id     <= '0;
          tile_x      <= '0;
          tile_y      <= '0;
          tile_base   <= '0;
          tile_len    <= (unit_q << 1) + unit_q;
          tile_valid  <= 1'b1;
          state       <= S_DISPATCH;
        end
        S_DISPATCH: begin
          issued      <= issued_nxt;
          completed   <= completed_nxt;
          outstanding <= outstanding_nxt;
          tile_valid  <= valid_nxt;
          if (accept) begin
            tile_id <= tile_id + 6'd1;
            if (gx == GX_LAST) begin
              gx        <= '0;
              tile_x    <= '0;
              tile_y    <= tile_y + unit_q;
              row_base  <= row_base + row_step;
              tile_base <= row_base + row_step;
            end else begin
              gx        <= gx + 6'd1;
              tile_x    <= tile_x + unit_q;
              tile_base <= tile_base + unit_q;
            end
          end
          if (issued_nxt == N_LAST) state <= S_WAIT;
        end
        S_WAIT: begin
          completed   <= completed_nxt;
          outstanding <= outstanding_nxt;
          if (completed_nxt == N_LAST) state <= S_MERGE;
        end
        // merge_done only counts once the enable is actually visible to the merger.
        S_MERGE: if (merge_en && merge_done) begin
          merge_en   <= 1'b0;
          frame_done <= 1'b1;
          state      <= S_DONE;
        end else begin
          merge_en <= 1'b1;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`ifdef TILE_WDOG_EN
        S_ERR: begin
          tile_valid <= 1'b0;
          merge_en   <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase

`ifdef TILE_WDOG_EN
      if (state == S_CALC) wdog_cnt <= '0;
      else if (wdog_active) wdog_cnt <= wdog_nxt;
      if (wdog_trip) begin
        state      <= S_ERR;
        tile_valid <= 1'b0;
        merge_en   <= 1'b0;
        wdog_err   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: directed scenarios for tile_sched with hand-derived expectations.
// The watchdog scenario is built only when TILE_WDOG_EN is defined.
module tb_tile_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] size;
  logic        frame_start, tile_ready, done_valid, merge_done;
  logic        tile_valid;
  logic [5:0]  tile_id;
  logic [31:0] tile_x, tile_y, tile_base, tile_len;
  logic        merge_en, busy, frame_done, cfg_err, proto_err;
`ifdef TILE_WDOG_EN
  logic        wdog_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tile_sched #(
    .GRID(6),
`ifdef TILE_WDOG_EN
    .WDOG_CYCLES(100),
`endif
    .MAX_OUT(8)
  ) dut (
    .clk(clk), .reset(reset), .size(size), .frame_start(frame_start),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_id(tile_id),
    .tile_x(tile_x), .tile_y(tile_y), .tile_base(tile_base), .tile_len(tile_len),
    .done_valid(done_valid), .merge_en(merge_en), .merge_done(merge_done),
    .busy(busy), .frame_done(frame_done),
`ifdef TILE_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .cfg_err(cfg_err), .proto_err(proto_err)
  );

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered right after the edge that sampled the 36th done.
  task automatic finish_merge(input string tag);
    total++;
    if (merge_en !== 1'b0) begin
      bad++; $display("FAIL %s merge_en_before_rise: got %b want 0", tag, merge_en);
    end
    tick();
    total++;
    if (merge_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s merge_en_rise: got merge_en=%b busy=%b want 1 1", tag, merge_en, busy);
    end
    tick();
    merge_done = 1'b1;
    tick();
    merge_done = 1'b0;
    total++;
    if (frame_done !== 1'b1 || merge_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s frame_done_pulse: got fd=%b me=%b busy=%b want 1 0 1", tag, frame_done, merge_en, busy);
    end
    tick();
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s back_to_idle: got fd=%b busy=%b want 0 0", tag, frame_done, busy);
    end
  endtask

  // Full frame, ready always high, each done returned 5 cycles after its accept.
  task automatic run_frame(input logic [31:0] sz, input bit poke, input string tag);
    logic [31:0] unit, ex, ey, eb, el;
    int acc, dn, cyc;
    int due[$];
    bit merge_early;
    unit = sz >> 3;
    size = sz; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++;
    if (busy !== 1'b1 || cfg_err !== 1'b0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL %s start_flags: got busy=%b cfg=%b proto=%b want 1 0 0", tag, busy, cfg_err, proto_err);
    end
    acc = 0; dn = 0; cyc = 0; merge_early = 0;
    tile_ready = 1'b1;
    while (dn < 36 && cyc < 2000) begin
      done_valid = (due.size() > 0 && due[0] == cyc);
      if (done_valid) begin
        void'(due.pop_front());
        dn++;
      end
      frame_start = poke && (cyc == 10);
      size = (poke && cyc == 10) ? 32'd16 : sz;
      if (merge_en) merge_early = 1;
      if (tile_valid) begin
        ex = (acc % 6) * unit;
        ey = (acc / 6) * unit;
        eb = ey * sz + ex;
        el = 3 * unit;
        total++;
        if (tile_id !== 6'(acc) || tile_x !== ex || tile_y !== ey || tile_base !== eb || tile_len !== el) begin
          bad++;
          $display("FAIL %s tile_fields[%0d]: got id=%0d x=%0d y=%0d base=%0d len=%0d want id=%0d x=%0d y=%0d base=%0d len=%0d",
                   tag, acc, tile_id, tile_x, tile_y, tile_base, tile_len, acc, ex, ey, eb, el);
        end
        if (acc == 7 && sz == 32'd64) begin
          total++;
          if (tile_x !== 32'd8 || tile_y !== 32'd8 || tile_base !== 32'd520 || tile_len !== 32'd24) begin
            bad++; $display("FAIL %s tile7: got x=%0d y=%0d base=%0d len=%0d want 8 8 520 24", tag, tile_x, tile_y, tile_base, tile_len);
          end
        end
        due.push_back(cyc + 5);
        acc++;
      end
      tick();
      cyc++;
    end
    done_valid = 1'b0; frame_start = 1'b0; size = sz;
    total++;
    if (cyc >= 2000 || acc != 36 || merge_early || tile_valid !== 1'b0) begin
      bad++; $display("FAIL %s dispatch_summary: got accepts=%0d cycles=%0d merge_early=%0d valid=%b want 36 <2000 0 0",
                      tag, acc, cyc, merge_early, tile_valid);
    end
    finish_merge(tag);
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s no_restart: got busy=%b want 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; size = '0; frame_start = 1'b0; tile_ready = 1'b0; done_valid = 1'b0; merge_done = 1'b0;
    #3;
    total++;
    if ({tile_valid, tile_id, tile_x, tile_y, tile_base, tile_len, merge_en, busy, frame_done, cfg_err, proto_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got valid=%b id=%0d busy=%b cfg=%b proto=%b want all 0", tile_valid, tile_id, busy, cfg_err, proto_err);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    run_frame(32'd64, 1'b0, "nominal");
  endtask

  task automatic test_proto();
    done_valid = 1'b1;
    tick();
    done_valid = 1'b0;
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL proto_idle: got proto=%b busy=%b want 1 0", proto_err, busy);
    end
  endtask

  task automatic test_zero_unit();
    bit saw_valid;
    size = 32'd7; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    saw_valid = tile_valid;
    total++;
    if (frame_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL zero_calc: got fd=%b busy=%b want 0 1", frame_done, busy);
    end
    tick();
    saw_valid |= tile_valid;
    total++;
    if (frame_done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_done: got fd=%b cfg=%b busy=%b want 1 1 0", frame_done, cfg_err, busy);
    end
    tick();
    saw_valid |= tile_valid;
    total++;
    if (frame_done !== 1'b0 || cfg_err !== 1'b1 || saw_valid) begin
      bad++; $display("FAIL zero_after: got fd=%b cfg=%b saw_valid=%0d want 0 1 0", frame_done, cfg_err, saw_valid);
    end
    run_frame(32'd64, 1'b0, "after_zero");
  endtask

  // Backpressure, outstanding limit and simultaneous accept/done share one frame.
  task automatic test_backpressure();
    logic [5:0]  sid;
    logic [31:0] sx, sy, sb;
    bit held;
    int acc, dn, unstable, gaps, n, cyc;
    bit merge_early;
    size = 32'd64; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    acc = 0; dn = 0; unstable = 0; held = 0;
    for (int i = 0; i < 40; i++) begin
      tile_ready = i[0];
      if (held && tile_valid && (tile_id !== sid || tile_x !== sx || tile_y !== sy || tile_base !== sb)) unstable++;
      held = tile_valid && !tile_ready;
      sid = tile_id; sx = tile_x; sy = tile_y; sb = tile_base;
      if (tile_valid && tile_ready) acc++;
      tick();
    end
    total++;
    if (acc != 8 || tile_valid !== 1'b0 || tile_id !== 6'd8 || unstable != 0) begin
      bad++; $display("FAIL bp_limit: got accepts=%0d valid=%b id=%0d unstable=%0d want 8 0 8 0", acc, tile_valid, tile_id, unstable);
    end
    tile_ready = 1'b0; done_valid = 1'b1;
    tick();
    done_valid = 1'b0; dn = 1;
    n = 0;
    tile_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (tile_valid) n++;
      tick();
    end
    acc += n;
    total++;
    if (n != 1 || tile_valid !== 1'b0 || tile_id !== 6'd9) begin
      bad++; $display("FAIL bp_one_more: got accepts=%0d valid=%b id=%0d want 1 0 9", n, tile_valid, tile_id);
    end

    tile_ready = 1'b0; done_valid = 1'b1;
    tick();
    dn = 2;
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      tile_ready = 1'b1; done_valid = 1'b1;
      if (!tile_valid) gaps++;
      else acc++;
      dn++;
      tick();
    end
    done_valid = 1'b0;
    total++;
    if (gaps != 0 || tile_id !== 6'd29 || tile_valid !== 1'b1) begin
      bad++; $display("FAIL simul_20: got gaps=%0d id=%0d valid=%b want 0 29 1", gaps, tile_id, tile_valid);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (tile_valid) n++;
      tick();
    end
    acc += n;
    total++;
    if (n != 1 || tile_valid !== 1'b0) begin
      bad++; $display("FAIL simul_outstanding: got accepts=%0d valid=%b want 1 0", n, tile_valid);
    end

    merge_early = 0; cyc = 0;
    while (dn < 36 && cyc < 500) begin
      done_valid = (acc > dn);
      if (merge_en) merge_early = 1;
      if (tile_valid) acc++;
      if (done_valid) dn++;
      tick();
      cyc++;
    end
    done_valid = 1'b0;
    total++;
    if (cyc >= 500 || acc != 36 || merge_early) begin
      bad++; $display("FAIL bp_drain: got accepts=%0d cycles=%0d merge_early=%0d want 36 <500 0", acc, cyc, merge_early);
    end
    finish_merge("backpressure");
  endtask

  task automatic test_reset_in_wait();
    int acc, dn, cyc;
    int due[$];
    size = 32'd64; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tile_ready = 1'b1;
    acc = 0; dn = 0; cyc = 0;
    while (acc < 36 && cyc < 500) begin
      done_valid = (due.size() > 0 && due[0] == cyc);
      if (done_valid) begin
        void'(due.pop_front());
        dn++;
      end
      if (tile_valid) begin
        if (acc < 30) due.push_back(cyc + 1);
        acc++;
      end
      tick();
      cyc++;
    end
    done_valid = 1'b0;
    tick(); tick();
    total++;
    if (busy !== 1'b1 || tile_valid !== 1'b0 || merge_en !== 1'b0 || acc != 36) begin
      bad++; $display("FAIL wait_state: got busy=%b valid=%b me=%b accepts=%0d want 1 0 0 36", busy, tile_valid, merge_en, acc);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tile_valid, tile_id, tile_x, tile_y, tile_base, tile_len, merge_en, busy, frame_done, cfg_err, proto_err} !== '0) begin
      bad++; $display("FAIL async_reset_wait: got valid=%b id=%0d x=%0d len=%0d busy=%b want all 0", tile_valid, tile_id, tile_x, tile_len, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_frame(32'd64, 1'b1, "after_reset_busy_start");
  endtask

`ifdef TILE_WDOG_EN
  task automatic test_watchdog();
    int acc, dn, cyc;
    int due[$];
    bit early;
    size = 32'd64; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tile_ready = 1'b1;
    acc = 0; dn = 0; cyc = 0;
    while (dn < 10 && cyc < 500) begin
      done_valid = (due.size() > 0 && due[0] == cyc);
      if (done_valid) begin
        void'(due.pop_front());
        dn++;
      end
      if (tile_valid) begin
        if (acc < 10) due.push_back(cyc + 2);
        acc++;
      end
      tick();
      cyc++;
    end
    done_valid = 1'b0;
    early = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k < 100 && wdog_err) early = 1;
    end
    total++;
    if (early || wdog_err !== 1'b1 || tile_valid !== 1'b0 || merge_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL wdog_trip: got early=%0d wdog=%b valid=%b me=%b busy=%b want 0 1 0 0 1", early, wdog_err, tile_valid, merge_en, busy);
    end
    frame_start = 1'b1; done_valid = 1'b1; merge_done = 1'b1;
    tick();
    frame_start = 1'b0; done_valid = 1'b0; merge_done = 1'b0;
    repeat (5) tick();
    total++;
    if (wdog_err !== 1'b1 || busy !== 1'b1 || tile_valid !== 1'b0 || merge_en !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL wdog_hold: got wdog=%b busy=%b valid=%b me=%b fd=%b want 1 1 0 0 0", wdog_err, busy, tile_valid, merge_en, frame_done);
    end
    reset = 1'b1;
    #1;
    total++;
    if (wdog_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wdog_reset: got wdog=%b busy=%b want 0 0", wdog_err, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_proto();
    test_zero_unit();
    test_backpressure();
    test_reset_in_wait();
`ifdef TILE_WDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_sched.md
Name: tile_sched

Overview:
- Sequences one frame of face detection over the 6x6 grid of overlapping tiles that the detection cores process.
- Each tile is 3*unit_size square with unit_size = size/8; tile origins step by unit_size.
- Issues tile jobs to the core pool over a valid/ready handshake and counts completions.
- After all 36 tiles complete, holds the merge-stage enable (in_signal of the tile merger) high until the merger reports completion, then flags frame done.

Parameters:
- GRID, 6, tiles per row/column (GRID*GRID tiles per frame, 36 by default).
- MAX_OUT, 8, maximum tiles in flight (dispatched, not yet completed), 1..63.
- WDOG_CYCLES, 1000000, watchdog limit in cycles (used only with TILE_WDOG_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- size  in  32  image edge length in pixels; sampled on frame_start.
- frame_start  in  1  one-cycle request to process a frame; ignored unless IDLE.
- tile_valid  out  1  tile job offered.
- tile_ready  in  1  core pool accepts the job; transfer when valid&&ready.
- tile_id  out  6  gy*GRID+gx, row-major.
- tile_x  out  32  gx*unit_size.
- tile_y  out  32  gy*unit_size.
- tile_base  out  32  tile_y*size_q+tile_x, the linear origin in the merged image.
- tile_len  out  32  3*unit_size.
- done_valid  in  1  one-cycle pulse: one tile finished.
- merge_en  out  1  level enable to the merge stage.
- merge_done  in  1  merge stage finished; level or pulse.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  sticky: frame rejected because unit_size==0.
- proto_err  out  1  sticky: done_valid arrived with nothing in flight.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - State IDLE.
  - All outputs 0, including tile_* fields, cfg_err and proto_err.
  - Counters 0.
- Reset mid-frame aborts the frame immediately. No partial state survives.
- IDLE:
  - On frame_start, register size_q=size and unit_q=size>>3, then go to CALC.
  - cfg_err and proto_err clear on an accepted frame_start.
- CALC (1 cycle):
  - If unit_q==0: set cfg_err, pulse frame_done, return to IDLE. No tiles are issued.
  - Otherwise set gx=gy=0, issued=0, completed=0, outstanding=0, and go to DISPATCH.
- DISPATCH:
  - tile_valid is high while issued<GRID*GRID and outstanding<MAX_OUT.
  - tile_* fields are registered and stay stable while tile_valid is high and ready is low.
  - On valid&&ready: issued+1, advance gx (wrap to 0 at GRID-1, then gy+1), outstanding+1. The next tile is offered the following cycle; one transfer per cycle at most.
  - When issued==GRID*GRID, deassert tile_valid and go to WAIT.
- Completion counting, in DISPATCH and WAIT:
  - done_valid gives completed+1 and outstanding-1.
  - If an accept and a done occur in the same cycle, outstanding is unchanged.
  - done_valid with outstanding==0: set proto_err and leave the counters unchanged.
  - done_valid in IDLE, CALC, MERGE or DONE also sets proto_err.
- WAIT: when completed==GRID*GRID, go to MERGE. The check covers the case where the last done arrives in the same cycle the last tile is accepted.
- MERGE:
  - merge_en=1, registered, asserted the cycle after entry.
  - On merge_done=1, deassert merge_en and go to DONE.
  - merge_done sampled while the state is not MERGE is ignored.
- DONE (1 cycle): frame_done=1, then IDLE. busy falls with the return to IDLE.
- Width rules:
  - All address arithmetic is 32-bit unsigned and truncates on overflow.
  - tile_len=(unit_q<<1)+unit_q.
  - Multiplications use registered operands; one combinational multiply per field is allowed.
- frame_start is ignored while busy.

Optional Feature:
- Macro: TILE_WDOG_EN.
- When defined:
  - A 32-bit counter clears on entry to DISPATCH, on each done_valid and on merge_done; it increments otherwise in DISPATCH, WAIT and MERGE.
  - Reaching WDOG_CYCLES moves the block to state ERR: outputs tile_valid=0 and merge_en=0; output wdog_err (1 bit, sticky) is set; busy stays 1.
  - ERR exits only through reset.
- When undefined: no counter, no ERR state, no wdog_err port; behaviour is otherwise identical.

Test Plan:
- Nominal frame: size=64, unit=8, tile_ready=1 always, each done returned 5 cycles after accept.
  - Required: 36 tiles in row-major order; tile_id 7 has x=8, y=8, base=520; tile_len=24.
  - Required: merge_en rises after the 36th done; merge_done gives a frame_done pulse and busy=0.
- Backpressure and outstanding limit: MAX_OUT=8, done withheld.
  - Required: exactly 8 accepts, then tile_valid=0.
  - Required: toggling tile_ready holds fields stable; one done lets exactly one more tile issue.
- Simultaneous accept and done for 20 consecutive cycles.
  - Required: outstanding constant, with completed and issued each +20.
- Zero unit: size=7.
  - Required: cfg_err=1 and frame_done 2 cycles after frame_start; no tile_valid.
  - Required: a subsequent frame_start with size=64 clears cfg_err.
- Errors and reset:
  - Spurious done_valid in IDLE: proto_err=1.
  - Reset asserted asynchronously in WAIT: all outputs 0 immediately; a new frame runs clean.
  - frame_start while busy: no effect.
- With TILE_WDOG_EN and WDOG_CYCLES=100, with done withheld after dispatch:
  - Required: wdog_err=1 exactly 100 cycles after the last done, tile_valid=0, and the state held until reset.
